// File: rtl/sdr_pkg.sv
// Shared SDRAM bus definitions: command encoding, bank state and mode-register field decode.
// Used by sdr_ram_resp (optional error reporting via SDR_RESP_PROTO_CHK_EN) and bus checkers.
package sdr_pkg;

   // Encoded as {cs_n, ras_n, cas_n, we_n}; any deselect collapses to CmdDesel.
   typedef enum logic [3:0] {
      CmdLmr   = 4'b0000,
      CmdRef   = 4'b0001,
      CmdPre   = 4'b0010,
      CmdAct   = 4'b0011,
      CmdWrite = 4'b0100,
      CmdRead  = 4'b0101,
      CmdBst   = 4'b0110,
      CmdNop   = 4'b0111,
      CmdDesel = 4'b1000
   } cmd_t;

   typedef enum logic {
      BankIdle   = 1'b0,
      BankActive = 1'b1
   } bank_st_t;

   // Burst length is held as a column wrap mask (BL-1).
   localparam logic [2:0] BlMaskRst = 3'd0;
   localparam logic [1:0] ClRst     = 2'd3;
   localparam logic [1:0] ClMin     = 2'd2;

   function automatic cmd_t cmd_decode(input logic cs_n, input logic ras_n,
                                       input logic cas_n, input logic we_n);
      if (cs_n) return CmdDesel;
      return cmd_t'({1'b0, ras_n, cas_n, we_n});
   endfunction

   function automatic logic [2:0] mr_bl_mask(input logic [2:0] field);
      case (field)
         3'd1:    return 3'd1;
         3'd2:    return 3'd3;
         3'd3:    return 3'd7;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [1:0] mr_cl(input logic [2:0] field);
      return (field == 3'd2) ? 2'd2 : 2'd3;
   endfunction

endpackage

// File: rtl/sdr_ram_resp_if.sv
// SDRAM bus with split data: the controller is master, the memory responder is slave.
interface sdr_ram_resp_if #(
   parameter int unsigned SDR_DW = 16,
   parameter int unsigned SDR_BW = SDR_DW / 8
);
   logic              sdr_cke;
   logic              sdr_cs_n;
   logic              sdr_ras_n;
   logic              sdr_cas_n;
   logic              sdr_we_n;
   logic [1:0]        sdr_ba;
   logic [12:0]       sdr_addr;
   logic [SDR_BW-1:0] sdr_dqm;
   logic [SDR_DW-1:0] sdr_dq_i;
   logic [SDR_DW-1:0] sdr_dq_o;
   logic [SDR_BW-1:0] sdr_dq_oe_n;

   modport master (
      output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
      output sdr_ba, sdr_addr, sdr_dqm, sdr_dq_i,
      input  sdr_dq_o, sdr_dq_oe_n
   );

   modport slave (
      input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
      input  sdr_ba, sdr_addr, sdr_dqm, sdr_dq_i,
      output sdr_dq_o, sdr_dq_oe_n
   );
endinterface

// File: rtl/sdr_resp_bank.sv
// One SDRAM bank: IDLE/ACTIVE state, open-row register and per-bank illegal-command detect.
module sdr_resp_bank
   import sdr_pkg::*;
#(
   parameter int unsigned RowW = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  cmd_t            cmd_i,
   input  logic            sel_i,
   input  logic            all_i,
   input  logic [RowW-1:0] row_i,
   output logic            active_o,
   output logic [RowW-1:0] row_o,
   output logic            err_o
);

   bank_st_t        st_d, st_q;
   logic [RowW-1:0] row_d, row_q;

   always_comb begin
      st_d  = st_q;
      row_d = row_q;
      if (cmd_i == CmdAct && sel_i && st_q == BankIdle) begin
         st_d  = BankActive;
         row_d = row_i;
      end
      if (cmd_i == CmdPre && (sel_i || all_i)) begin
         st_d = BankIdle;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q  <= BankIdle;
         row_q <= '0;
      end else begin
         st_q  <= st_d;
         row_q <= row_d;
      end
   end

   assign active_o = (st_q == BankActive);
   assign row_o    = row_q;
   assign err_o    = sel_i && (((cmd_i == CmdAct) && (st_q == BankActive)) ||
                               ((cmd_i == CmdRead || cmd_i == CmdWrite) && (st_q == BankIdle)));

endmodule

// File: rtl/sdr_ram_resp.sv
// SDRAM device-side responder: command decode, mode register, bursts, CL pipe and storage.
// Define SDR_RESP_PROTO_CHK_EN to report illegal commands on err_proto/err_cnt.
module sdr_ram_resp
   import sdr_pkg::*;
#(
   parameter int unsigned SDR_DW       = 16,
   parameter int unsigned SDR_BW       = 2,
   parameter int unsigned MEM_ROW_BITS = 2,
   parameter int unsigned MEM_COL_BITS = 6
) (
   input  logic          sdram_clk,
   input  logic          sdram_reset,
   sdr_ram_resp_if.slave bus,
   output logic          err_proto,
   output logic [7:0]    err_cnt
);

   localparam int unsigned AW    = 2 + MEM_ROW_BITS + MEM_COL_BITS;
   localparam int unsigned Depth = 1 << AW;

   cmd_t                    cmd;
   logic [3:0]              bank_sel, bank_active, bank_err;
   logic [MEM_ROW_BITS-1:0] bank_row [4];
   logic                    illegal, rd_go, wr_go, lmr_go, bst_kill;

   logic [2:0] bl_mask_d, bl_mask_q;
   logic [1:0] cl_d, cl_q;

   logic                    bst_act_d, bst_act_q, bst_wr_d, bst_wr_q;
   logic [1:0]              bst_ba_d, bst_ba_q;
   logic [MEM_ROW_BITS-1:0] bst_row_d, bst_row_q;
   logic [MEM_COL_BITS-1:0] bst_col_d, bst_col_q;
   logic [2:0]              bst_cnt_d, bst_cnt_q;

   logic                    iss_v, iss_wr;
   logic [1:0]              iss_ba;
   logic [MEM_ROW_BITS-1:0] iss_row;
   logic [MEM_COL_BITS-1:0] iss_col, col_mask;
   logic [AW-1:0]           iss_idx;

   logic [SDR_DW-1:0] mem_q [Depth];
   logic [SDR_BW-1:0] mem_we;
   logic [SDR_DW-1:0] rd_data;

   logic              p0_v_d, p0_v_q, p1_v_d, p1_v_q, out_v;
   logic [SDR_DW-1:0] p0_dat_d, p0_dat_q, p1_dat_d, p1_dat_q, out_dat;
   logic [SDR_BW-1:0] dqm1_d, dqm1_q, dqm2_d, dqm2_q;
   logic [SDR_DW-1:0] dq_o_d, dq_o_q;
   logic [SDR_BW-1:0] oe_n_d, oe_n_q;

   // Suspended clock: decode as NOP so nothing in the banks or mode register moves.
   assign cmd = bus.sdr_cke ? cmd_decode(bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n,
                                         bus.sdr_we_n) : CmdNop;
   assign bank_sel = 4'b0001 << bus.sdr_ba;

   for (genvar b = 0; b < 4; b++) begin : g_bank
      sdr_resp_bank #(
         .RowW (MEM_ROW_BITS)
      ) u_bank (
         .clk_i    (sdram_clk),
         .rst_i    (sdram_reset),
         .cmd_i    (cmd),
         .sel_i    (bank_sel[b]),
         .all_i    (bus.sdr_addr[10]),
         .row_i    (bus.sdr_addr[MEM_ROW_BITS-1:0]),
         .active_o (bank_active[b]),
         .row_o    (bank_row[b]),
         .err_o    (bank_err[b])
      );
   end

   assign illegal  = (|bank_err) || ((cmd == CmdLmr || cmd == CmdRef) && (|bank_active));
   assign lmr_go   = (cmd == CmdLmr) && !(|bank_active);
   assign rd_go    = (cmd == CmdRead) && bank_active[bus.sdr_ba];
   assign wr_go    = (cmd == CmdWrite) && bank_active[bus.sdr_ba];
   assign bst_kill = (cmd == CmdBst) ||
                     ((cmd == CmdPre) && (bus.sdr_addr[10] || bus.sdr_ba == bst_ba_q));
   assign col_mask = MEM_COL_BITS'(bl_mask_q);

   always_comb begin
      bl_mask_d = bl_mask_q;
      cl_d      = cl_q;
      bst_act_d = bst_act_q;
      bst_wr_d  = bst_wr_q;
      bst_ba_d  = bst_ba_q;
      bst_row_d = bst_row_q;
      bst_col_d = bst_col_q;
      bst_cnt_d = bst_cnt_q;
      iss_v     = 1'b0;
      iss_wr    = bst_wr_q;
      iss_ba    = bst_ba_q;
      iss_row   = bst_row_q;
      iss_col   = bst_col_q;
      if (lmr_go) begin
         bl_mask_d = mr_bl_mask(bus.sdr_addr[2:0]);
         cl_d      = mr_cl(bus.sdr_addr[6:4]);
      end
      if (rd_go || wr_go) begin
         iss_v     = 1'b1;
         iss_wr    = wr_go;
         iss_ba    = bus.sdr_ba;
         iss_row   = bank_row[bus.sdr_ba];
         iss_col   = bus.sdr_addr[MEM_COL_BITS-1:0];
         bst_act_d = (bl_mask_q != 3'd0);
         bst_wr_d  = wr_go;
         bst_ba_d  = bus.sdr_ba;
         bst_row_d = bank_row[bus.sdr_ba];
         bst_col_d = bus.sdr_addr[MEM_COL_BITS-1:0];
         bst_cnt_d = 3'd1;
      end else if (bst_act_q && bus.sdr_cke) begin
         if (bst_kill) begin
            bst_act_d = 1'b0;
         end else begin
            // Sequential order wrapping inside the BL-aligned block.
            iss_v     = 1'b1;
            iss_col   = (bst_col_q & ~col_mask) |
                        ((bst_col_q + MEM_COL_BITS'(bst_cnt_q)) & col_mask);
            bst_cnt_d = bst_cnt_q + 3'd1;
            bst_act_d = (bst_cnt_q != bl_mask_q);
         end
      end
   end

   assign iss_idx = {iss_ba, iss_row, iss_col};
   assign mem_we  = (iss_v && iss_wr) ? ~bus.sdr_dqm : '0;
   assign rd_data = mem_q[iss_idx];

   always_ff @(posedge sdram_clk) begin
      for (int l = 0; l < int'(SDR_BW); l++) begin
         if (mem_we[l]) mem_q[iss_idx][l*8 +: 8] <= bus.sdr_dq_i[l*8 +: 8];
      end
   end

   always_comb begin
      p0_v_d   = p0_v_q;
      p0_dat_d = p0_dat_q;
      p1_v_d   = p1_v_q;
      p1_dat_d = p1_dat_q;
      dqm1_d   = dqm1_q;
      dqm2_d   = dqm2_q;
      dq_o_d   = dq_o_q;
      oe_n_d   = oe_n_q;
      out_v    = (cl_q == ClMin) ? p0_v_q : p1_v_q;
      out_dat  = (cl_q == ClMin) ? p0_dat_q : p1_dat_q;
      if (bus.sdr_cke) begin
         p0_v_d   = iss_v && !iss_wr;
         p0_dat_d = rd_data;
         p1_v_d   = p0_v_q;
         p1_dat_d = p0_dat_q;
         dqm1_d   = bus.sdr_dqm;
         dqm2_d   = dqm1_q;
         dq_o_d   = out_v ? out_dat : '0;
         oe_n_d   = out_v ? dqm2_q : '1;
      end
   end

   always_ff @(posedge sdram_clk) begin
      if (sdram_reset) begin
         bl_mask_q <= BlMaskRst;
         cl_q      <= ClRst;
         bst_act_q <= 1'b0;
         bst_wr_q  <= 1'b0;
         bst_ba_q  <= '0;
         bst_row_q <= '0;
         bst_col_q <= '0;
         bst_cnt_q <= '0;
         p0_v_q    <= 1'b0;
         p0_dat_q  <= '0;
         p1_v_q    <= 1'b0;
         p1_dat_q  <= '0;
         dqm1_q    <= '0;
         dqm2_q    <= '0;
         dq_o_q    <= '0;
         oe_n_q    <= '1;
      end else begin
         bl_mask_q <= bl_mask_d;
         cl_q      <= cl_d;
         bst_act_q <= bst_act_d;
         bst_wr_q  <= bst_wr_d;
         bst_ba_q  <= bst_ba_d;
         bst_row_q <= bst_row_d;
         bst_col_q <= bst_col_d;
         bst_cnt_q <= bst_cnt_d;
         p0_v_q    <= p0_v_d;
         p0_dat_q  <= p0_dat_d;
         p1_v_q    <= p1_v_d;
         p1_dat_q  <= p1_dat_d;
         dqm1_q    <= dqm1_d;
         dqm2_q    <= dqm2_d;
         dq_o_q    <= dq_o_d;
         oe_n_q    <= oe_n_d;
      end
   end

   assign bus.sdr_dq_o    = dq_o_q;
   assign bus.sdr_dq_oe_n = oe_n_q;

`ifdef SDR_RESP_PROTO_CHK_EN
   logic       err_proto_d, err_proto_q;
   logic [7:0] err_cnt_d, err_cnt_q;

   always_comb begin
      err_proto_d = illegal;
      err_cnt_d   = err_cnt_q;
      if (illegal && err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge sdram_clk) begin
      if (sdram_reset) begin
         err_proto_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         err_proto_q <= err_proto_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign err_proto = err_proto_q;
   assign err_cnt   = err_cnt_q;
`else
   logic unused_illegal;
   assign unused_illegal = illegal;
   assign err_proto      = 1'b0;
   assign err_cnt        = '0;
`endif

   // Upper row/column address bits alias by design.
   logic unused_addr;
   assign unused_addr = ^bus.sdr_addr;

endmodule

// File: tb/tb_sdr_ram_resp.sv
// Directed, table-driven bench for sdr_ram_resp plus hand sequences for multi-cycle cases.
module tb_sdr_ram_resp;

   localparam logic [3:0] Nop = 4'b0111, Lmr = 4'b0000, Pre = 4'b0010, Act = 4'b0011;
   localparam logic [3:0] Wr  = 4'b0100, Rd  = 4'b0101, Bst = 4'b0110;
`ifdef SDR_RESP_PROTO_CHK_EN
   localparam bit ChkEn = 1'b1;
`else
   localparam bit ChkEn = 1'b0;
`endif

   typedef struct {
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [12:0] addr;
      logic [1:0]  dqm;
      logic [15:0] din;
      logic [15:0] exp_dq;
      logic [1:0]  exp_oe;
   } vec_t;

   vec_t       vecs[$];
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       err_proto;
   logic [7:0] err_cnt;
   int         checks = 0;
   int         errors = 0;
   int         words;

   always #5 clk = ~clk;

   sdr_ram_resp_if #(.SDR_DW(16), .SDR_BW(2)) bus ();

   sdr_ram_resp #(
      .SDR_DW       (16),
      .SDR_BW       (2),
      .MEM_ROW_BITS (2),
      .MEM_COL_BITS (6)
   ) dut (
      .sdram_clk   (clk),
      .sdram_reset (rst),
      .bus         (bus),
      .err_proto   (err_proto),
      .err_cnt     (err_cnt)
   );

   task automatic tv(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [1:0] m, input logic [15:0] d, input logic [15:0] ed,
                     input logic [1:0] eo);
      vec_t v;
      v.cmd = c; v.ba = ba; v.addr = a; v.dqm = m; v.din = d; v.exp_dq = ed; v.exp_oe = eo;
      vecs.push_back(v);
   endtask

   // Drive one command for the next rising edge, then sample just after it.
   task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                        input logic [1:0] m, input logic [15:0] d);
      @(negedge clk);
      {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = c;
      bus.sdr_ba   = ba;
      bus.sdr_addr = a;
      bus.sdr_dqm  = m;
      bus.sdr_dq_i = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Data is only meaningful on lanes being driven.
   task automatic chk_out(input string nm, input logic [15:0] ed, input logic [1:0] eo);
      chk_val({nm, ".oe_n"}, 32'(bus.sdr_dq_oe_n), 32'(eo));
      if (eo != 2'b11) chk_val({nm, ".dq"}, 32'(bus.sdr_dq_o), 32'(ed));
   endtask

   task automatic chk_err(input string nm, input logic ep, input logic [7:0] ec);
      chk_val({nm, ".err_proto"}, 32'(err_proto), 32'(ep));
      chk_val({nm, ".err_cnt"}, 32'(err_cnt), 32'(ec));
   endtask

   initial begin
      bus.sdr_cke  = 1'b1;
      {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = Nop;
      bus.sdr_ba   = '0;
      bus.sdr_addr = '0;
      bus.sdr_dqm  = '0;
      bus.sdr_dq_i = '0;
      rst = 1'b1;
      drive(Nop, 0, 0, 0, 0);
      drive(Nop, 0, 0, 0, 0);
      rst = 1'b0;
      chk_val("reset.dq", 32'(bus.sdr_dq_o), 32'h0);
      chk_out("reset", 16'h0, 2'b11);
      chk_err("reset", 1'b0, 8'd0);

      // CL=2 BL=4, bank 0 row 5, write then read column 8.
      tv(Lmr, 0, 13'h022, 0, 0, 0, 2'b11);
      tv(Act, 0, 13'd5, 0, 0, 0, 2'b11);
      tv(Wr,  0, 13'd8, 0, 16'h0001, 0, 2'b11);
      tv(Nop, 0, 0, 0, 16'h0002, 0, 2'b11);
      tv(Nop, 0, 0, 0, 16'h0003, 0, 2'b11);
      tv(Nop, 0, 0, 0, 16'h0004, 0, 2'b11);
      tv(Rd,  0, 13'd8, 0, 0, 0, 2'b11);
      tv(Nop, 0, 0, 0, 0, 16'h0001, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h0002, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h0003, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h0004, 2'b00);
      tv(Nop, 0, 0, 0, 0, 0, 2'b11);
      // CL=3 BL=8, fill columns 8..15 then read from 13 to see the wrap.
      tv(Pre, 0, 13'h400, 0, 0, 0, 2'b11);
      tv(Lmr, 0, 13'h033, 0, 0, 0, 2'b11);
      tv(Act, 0, 13'd5, 0, 0, 0, 2'b11);
      tv(Wr,  0, 13'd8, 0, 16'h0108, 0, 2'b11);
      for (int c = 9; c < 16; c++) tv(Nop, 0, 0, 0, 16'h0100 + 16'(c), 0, 2'b11);
      tv(Rd,  0, 13'd13, 0, 0, 0, 2'b11);
      tv(Nop, 0, 0, 0, 0, 0, 2'b11);
      tv(Nop, 0, 0, 0, 0, 16'h010D, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h010E, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h010F, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h0108, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h0109, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h010A, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h010B, 2'b00);
      tv(Nop, 0, 0, 0, 0, 16'h010C, 2'b00);
      tv(Nop, 0, 0, 0, 0, 0, 2'b11);
      // CL=2 BL=1: write byte mask, then read with read-mask latency 2.
      tv(Pre, 0, 13'h400, 0, 0, 0, 2'b11);
      tv(Lmr, 0, 13'h020, 0, 0, 0, 2'b11);
      tv(Act, 2, 13'd3, 0, 0, 0, 2'b11);
      tv(Wr,  2, 13'd0, 2'b00, 16'hAAAA, 0, 2'b11);
      tv(Wr,  2, 13'd0, 2'b10, 16'h5555, 0, 2'b11);
      tv(Nop, 0, 0, 2'b00, 0, 0, 2'b11);
      tv(Rd,  2, 13'd0, 2'b00, 0, 0, 2'b11);
      tv(Nop, 0, 0, 2'b01, 0, 16'hAA55, 2'b00);
      tv(Rd,  2, 13'd0, 2'b00, 0, 0, 2'b11);
      tv(Nop, 0, 0, 2'b00, 0, 16'hAA55, 2'b01);
      tv(Nop, 0, 0, 2'b00, 0, 0, 2'b11);

      foreach (vecs[i]) begin
         drive(vecs[i].cmd, vecs[i].ba, vecs[i].addr, vecs[i].dqm, vecs[i].din);
         chk_out($sformatf("vec%0d", i), vecs[i].exp_dq, vecs[i].exp_oe);
      end

      // BL=8 read stopped by BURST_TERMINATE two edges after the READ.
      drive(Pre, 0, 13'h400, 0, 0);
      drive(Lmr, 0, 13'h033, 0, 0);
      drive(Act, 0, 13'd5, 0, 0);
      drive(Rd, 0, 13'd8, 0, 0);
      drive(Nop, 0, 0, 0, 0);
      drive(Bst, 0, 0, 0, 0);
      words = 0;
      chk_out("bst_w0", 16'h0108, 2'b00);
      if (bus.sdr_dq_oe_n != 2'b11) words++;
      drive(Nop, 0, 0, 0, 0);
      chk_out("bst_w1", 16'h0109, 2'b00);
      if (bus.sdr_dq_oe_n != 2'b11) words++;
      for (int k = 0; k < 3; k++) begin
         drive(Nop, 0, 0, 0, 0);
         chk_out($sformatf("bst_idle%0d", k), 16'h0, 2'b11);
         if (bus.sdr_dq_oe_n != 2'b11) words++;
      end
      chk_val("bst_words", 32'(words), 32'd2);

      // Reset two edges into a BL=8 CL=3 read.
      drive(Rd, 0, 13'd8, 0, 0);
      drive(Nop, 0, 0, 0, 0);
      rst = 1'b1;
      drive(Nop, 0, 0, 0, 0);
      rst = 1'b0;
      chk_out("rst_abort", 16'h0, 2'b11);
      chk_val("rst_abort.dq", 32'(bus.sdr_dq_o), 32'h0);

      // READ on idle bank 1, then on bank 0 which reset closed.
      drive(Rd, 1, 13'd0, 0, 0);
      chk_err("rd_idle_b1", ChkEn, ChkEn ? 8'd1 : 8'd0);
      drive(Nop, 0, 0, 0, 0);
      chk_err("rd_idle_b1_clr", 1'b0, ChkEn ? 8'd1 : 8'd0);
      drive(Rd, 0, 13'd8, 0, 0);
      chk_err("rd_idle_b0", ChkEn, ChkEn ? 8'd2 : 8'd0);
      for (int k = 0; k < 4; k++) begin
         drive(Nop, 0, 0, 0, 0);
         chk_out($sformatf("rd_idle_nodata%0d", k), 16'h0, 2'b11);
      end

      // Mode after reset is CL=3 BL=1.
      drive(Act, 0, 13'd5, 0, 0);
      drive(Rd, 0, 13'd8, 0, 0);
      drive(Nop, 0, 0, 0, 0);
      chk_out("cl3_t1", 16'h0, 2'b11);
      drive(Nop, 0, 0, 0, 0);
      chk_out("cl3_t2", 16'h0108, 2'b00);
      drive(Nop, 0, 0, 0, 0);
      chk_out("bl1_end", 16'h0, 2'b11);

      // LMR with a bank open is ignored: CL stays 3.
      drive(Lmr, 0, 13'h022, 0, 0);
      chk_err("lmr_active", ChkEn, ChkEn ? 8'd3 : 8'd0);
      drive(Rd, 0, 13'd8, 0, 0);
      drive(Nop, 0, 0, 0, 0);
      chk_out("lmr_ign_t1", 16'h0, 2'b11);
      drive(Nop, 0, 0, 0, 0);
      chk_out("lmr_ign_t2", 16'h0108, 2'b00);
      drive(Nop, 0, 0, 0, 0);
      chk_out("lmr_ign_end", 16'h0, 2'b11);

      // Clock suspend holds the read pipe.
      drive(Rd, 0, 13'd8, 0, 0);
      bus.sdr_cke = 1'b0;
      drive(Nop, 0, 0, 0, 0);
      chk_out("cke_hold0", 16'h0, 2'b11);
      drive(Nop, 0, 0, 0, 0);
      chk_out("cke_hold1", 16'h0, 2'b11);
      bus.sdr_cke = 1'b1;
      drive(Nop, 0, 0, 0, 0);
      chk_out("cke_t1", 16'h0, 2'b11);
      drive(Nop, 0, 0, 0, 0);
      chk_out("cke_t2", 16'h0108, 2'b00);
      drive(Nop, 0, 0, 0, 0);
      chk_out("cke_end", 16'h0, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
